// File: rtl/axis_burst_framer_if.sv
// Bundle of the sample-in, flush and beat-out handshake signals of axis_burst_framer.
// The slave modport is the framer's view; the master modport is the driver's view.
interface axis_burst_framer_if #(
  parameter int IN_WIDTH    = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int LEVEL_WIDTH = 7
);
  logic [IN_WIDTH-1:0]    i_data;
  logic                   i_valid;
  logic                   o_ready;
  logic                   i_flush;
  logic                   o_flush_done;
  logic [DATA_WIDTH-1:0]  m_tdata;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   m_tready;
  logic [LEVEL_WIDTH-1:0] o_level;
  logic                   o_busy;

  modport slave (
    input  i_data, i_valid, i_flush, m_tready,
    output o_ready, o_flush_done, m_tdata, m_tvalid, m_tlast, o_level, o_busy
  );

  modport master (
    output i_data, i_valid, i_flush, m_tready,
    input  o_ready, o_flush_done, m_tdata, m_tvalid, m_tlast, o_level, o_busy
  );
endinterface

// File: rtl/axis_burst_framer.sv
// Packs narrow samples into wide beats, buffers them in a show-ahead FIFO and releases
// them only as whole tlast-terminated bursts; a flush zero-pads a trailing partial burst.
module axis_burst_framer #(
  parameter int IN_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  axis_burst_framer_if.slave   bus
);
  localparam int RATIO = DATA_WIDTH / IN_WIDTH;
  localparam int PCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [PCW-1:0] PACK_LAST = PCW'(RATIO - 1);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    BURST_CNT = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [PCW-1:0] PACK_ONE  = PCW'(1);
  localparam logic [BW-1:0]  BEAT_ONE  = BW'(1);

  typedef enum logic [1:0] {W_RUN, FLUSH_PACK, FLUSH_PAD} w_state_e;
  typedef enum logic {R_IDLE, R_SEND} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  run_q;
  logic [PCW-1:0]        pack_cnt_q, pack_cnt_d;
  logic [DATA_WIDTH-1:0] pack_buf_q, pack_buf_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [BW-1:0]         wr_mod_q, wr_mod_d;
  logic [BW-1:0]         rd_beat_q, rd_beat_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                  flushing, flush_done, pack_flush_wr, pad_wr;
  logic                  space, ready, accept, pack_write, wr_en, pop;
  logic                  tvalid, tlast;
  logic [DATA_WIDTH-1:0] assembled, wr_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state_q <= W_RUN;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // The flush walks pack -> pad and only reports done once the write side is burst aligned.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_RUN:      if (bus.i_flush) w_state_d = FLUSH_PACK;
      FLUSH_PACK: if ((pack_cnt_q == '0) || space) w_state_d = FLUSH_PAD;
      FLUSH_PAD:  if (wr_mod_q == '0) w_state_d = W_RUN;
      default:    w_state_d = W_RUN;
    endcase
  end

  always_comb begin
    flushing      = (w_state_q != W_RUN);
    pack_flush_wr = (w_state_q == FLUSH_PACK) && (pack_cnt_q != '0) && space;
    pad_wr        = (w_state_q == FLUSH_PAD) && (wr_mod_q != '0) && space;
    flush_done    = (w_state_q == FLUSH_PAD) && (wr_mod_q == '0);
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (count_q >= BURST_CNT) r_state_d = R_SEND;
      R_SEND:  if (bus.m_tready && (rd_beat_q == BEAT_LAST)) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tvalid = (r_state_q == R_SEND);
    tlast  = tvalid && (rd_beat_q == BEAT_LAST);
    pop    = tvalid && bus.m_tready;
  end

  always_comb begin
    space      = (count_q < DEPTH_CNT);
    ready      = run_q && space && !flushing;
    accept     = bus.i_valid && ready;
    pack_write = accept && (pack_cnt_q == PACK_LAST);

    assembled = pack_buf_q;
    for (int k = 0; k < RATIO; k++) begin
      if (PCW'(k) == pack_cnt_q) assembled[k*IN_WIDTH +: IN_WIDTH] = bus.i_data;
    end

    // Unfilled lanes of pack_buf_q are always zero, so a flushed partial beat is already padded.
    wr_en   = pack_write || pack_flush_wr || pad_wr;
    wr_data = '0;
    if (pack_write) wr_data = assembled;
    else if (pack_flush_wr) wr_data = pack_buf_q;

    pack_cnt_d = pack_cnt_q;
    pack_buf_d = pack_buf_q;
    if (accept) begin
      pack_cnt_d = pack_write ? '0 : (pack_cnt_q + PACK_ONE);
      pack_buf_d = pack_write ? '0 : assembled;
    end else if (pack_flush_wr) begin
      pack_cnt_d = '0;
      pack_buf_d = '0;
    end

    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    wr_mod_d = wr_mod_q;
    if (wr_en) wr_mod_d = (wr_mod_q == BEAT_LAST) ? '0 : (wr_mod_q + BEAT_ONE);

    rd_beat_d = rd_beat_q;
    if (pop) rd_beat_d = (rd_beat_q == BEAT_LAST) ? '0 : (rd_beat_q + BEAT_ONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q      <= 1'b0;
      pack_cnt_q <= '0;
      pack_buf_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_mod_q   <= '0;
      rd_beat_q  <= '0;
    end else begin
      run_q      <= 1'b1;
      pack_cnt_q <= pack_cnt_d;
      pack_buf_q <= pack_buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_mod_q   <= wr_mod_d;
      rd_beat_q  <= rd_beat_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign bus.o_ready      = ready;
  assign bus.o_flush_done = flush_done;
  assign bus.m_tdata      = mem[rd_ptr_q];
  assign bus.m_tvalid     = tvalid;
  assign bus.m_tlast      = tlast;
  assign bus.o_level      = count_q;
  assign bus.o_busy       = (count_q != '0) || (pack_cnt_q != '0) || flushing;
endmodule

// File: tb/tb_axis_burst_framer.sv
// Scoreboard bench for axis_burst_framer: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every accepted output beat.
module tb_axis_burst_framer;
  localparam int IN_WIDTH   = 32;
  localparam int DATA_WIDTH = 64;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;

  axis_burst_framer_if #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEVEL_WIDTH(7)) bus ();

  axis_burst_framer #(
    .IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;
  int bursts_seen = 0;

  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];

  logic [63:0] m_buf = '0;
  int          m_lane = 0;
  int          m_wmod = 0;

  logic        prev_hold = 1'b0;
  logic        prev_lasths = 1'b0;
  logic [63:0] hold_data;
  logic        hold_last;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_beat(input logic [63:0] b);
    exp_q.push_back({(m_wmod == BURST_LEN - 1), b});
    m_wmod = (m_wmod + 1) % BURST_LEN;
  endtask

  task automatic model_accept(input logic [31:0] d);
    m_buf[m_lane*32 +: 32] = d;
    m_lane++;
    if (m_lane == 2) begin
      push_beat(m_buf);
      m_buf = '0;
      m_lane = 0;
    end
  endtask

  task automatic model_flush();
    if (m_lane != 0) begin
      push_beat(m_buf);
      m_buf = '0;
      m_lane = 0;
    end
    while (m_wmod != 0) push_beat(64'h0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] d);
    int n;
    n = 0;
    bus.i_data = d;
    bus.i_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: sample 0x%0h not accepted, o_ready=%0b required 1", d, bus.o_ready);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d);
    #1;
  endtask

  task automatic push_range(input logic [31:0] first, input int count);
    for (int i = 0; i < count; i++) apply_stimulus(first + 32'(i));
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_pending", 64'(exp_q.size()), 64'd0);
    cycles(3);
  endtask

  // Monitor: compares each handshaked beat and checks hold-stability and the idle gap after tlast.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_lasths = 1'b0;
    end else begin
      if (prev_hold) begin
        check_output("hold_valid", 64'(bus.m_tvalid), 64'd1);
        check_output("hold_data", bus.m_tdata, hold_data);
        check_output("hold_last", 64'(bus.m_tlast), 64'(hold_last));
      end
      if (prev_lasths) check_output("idle_after_last", 64'(bus.m_tvalid), 64'd0);
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got 0x%0h with no beat expected", bus.m_tdata);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check_output("beat_data", bus.m_tdata, e[63:0]);
          check_output("beat_last", 64'(bus.m_tlast), 64'(e[64]));
        end
        got_q.push_back({bus.m_tlast, bus.m_tdata});
        beats_seen++;
        if (bus.m_tlast) bursts_seen++;
      end
      prev_hold   = bus.m_tvalid && !bus.m_tready;
      hold_data   = bus.m_tdata;
      hold_last   = bus.m_tlast;
      prev_lasths = bus.m_tvalid && bus.m_tready && bus.m_tlast;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b0, n, pulses;
    logic done_seen;

    rst_n = 1'b0;
    bus.i_data = '0;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.m_tready = 1'b1;
    cycles(3);

    check_output("rst_ready", 64'(bus.o_ready), 64'd0);
    check_output("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    check_output("rst_tlast", 64'(bus.m_tlast), 64'd0);
    check_output("rst_flush_done", 64'(bus.o_flush_done), 64'd0);
    check_output("rst_level", 64'(bus.o_level), 64'd0);
    check_output("rst_busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;
    check_output("ready_before_first_edge", 64'(bus.o_ready), 64'd0);
    cycles(1);
    check_output("ready_after_release", 64'(bus.o_ready), 64'd1);

    $display("[TB] burst release with 32 samples");
    got_q.delete();
    push_range(32'h1, 31);
    check_output("tvalid_after_31", 64'(bus.m_tvalid), 64'd0);
    push_range(32'h20, 1);
    wait_drain();
    check_output("t1_beats", 64'(got_q.size()), 64'd16);
    check_output("t1_beat0", got_q[0][63:0], 64'h00000002_00000001);
    check_output("t1_beat15", got_q[15][63:0], 64'h00000020_0000001F);
    check_output("t1_last14", 64'(got_q[14][64]), 64'd0);
    check_output("t1_last15", 64'(got_q[15][64]), 64'd1);
    check_output("t1_level", 64'(bus.o_level), 64'd0);

    $display("[TB] toggled tready with 64 samples");
    bus.m_tready = 1'b0;
    b0 = bursts_seen;
    push_range(32'h100, 64);
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      bus.m_tready = ~bus.m_tready;
      n++;
    end
    bus.m_tready = 1'b1;
    wait_drain();
    check_output("t2_bursts", 64'(bursts_seen - b0), 64'd2);

    $display("[TB] stall until full");
    bus.m_tready = 1'b0;
    b0 = bursts_seen;
    push_range(32'h1000, 128);
    check_output("t3_level_full", 64'(bus.o_level), 64'd64);
    check_output("t3_ready_full", 64'(bus.o_ready), 64'd0);
    check_output("t3_busy_full", 64'(bus.o_busy), 64'd1);
    bus.m_tready = 1'b1;
    wait_drain();
    check_output("t3_bursts", 64'(bursts_seen - b0), 64'd4);
    check_output("t3_level_empty", 64'(bus.o_level), 64'd0);
    check_output("t3_busy_empty", 64'(bus.o_busy), 64'd0);

    $display("[TB] flush of 5 samples");
    got_q.delete();
    b0 = bursts_seen;
    push_range(32'h1, 5);
    check_output("t4_tvalid_pre", 64'(bus.m_tvalid), 64'd0);
    pulse_flush();
    model_flush();
    pulses = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!done_seen) check_output("t4_ready_low", 64'(bus.o_ready), 64'd0);
      if (bus.o_flush_done) begin
        pulses++;
        done_seen = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check_output("t4_done_pulses", 64'(pulses), 64'd1);
    check_output("t4_ready_after", 64'(bus.o_ready), 64'd1);
    wait_drain();
    check_output("t4_beats", 64'(got_q.size()), 64'd16);
    check_output("t4_beat0", got_q[0][63:0], 64'h00000002_00000001);
    check_output("t4_beat1", got_q[1][63:0], 64'h00000004_00000003);
    check_output("t4_beat2", got_q[2][63:0], 64'h00000000_00000005);
    check_output("t4_beat15", got_q[15][63:0], 64'h0);
    check_output("t4_last15", 64'(got_q[15][64]), 64'd1);
    check_output("t4_bursts", 64'(bursts_seen - b0), 64'd1);

    $display("[TB] reset mid-burst");
    b0 = beats_seen;
    push_range(32'h2000, 32);
    n = 0;
    while (beats_seen < b0 + 7 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("t5_beats_before_reset", 64'(beats_seen - b0), 64'd7);
    rst_n = 1'b0;
    #1;
    check_output("t5_tvalid", 64'(bus.m_tvalid), 64'd0);
    check_output("t5_tlast", 64'(bus.m_tlast), 64'd0);
    check_output("t5_level", 64'(bus.o_level), 64'd0);
    check_output("t5_busy", 64'(bus.o_busy), 64'd0);
    check_output("t5_ready", 64'(bus.o_ready), 64'd0);
    exp_q.delete();
    m_buf = '0;
    m_lane = 0;
    m_wmod = 0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    check_output("t5_ready_release", 64'(bus.o_ready), 64'd1);
    check_output("t5_level_release", 64'(bus.o_level), 64'd0);
    got_q.delete();
    b0 = bursts_seen;
    push_range(32'h3000, 32);
    wait_drain();
    check_output("t5_bursts", 64'(bursts_seen - b0), 64'd1);
    check_output("t5_beat0", got_q[0][63:0], 64'h00003001_00003000);
    check_output("t5_last15", 64'(got_q[15][64]), 64'd1);

    $display("[TB] empty flush");
    b0 = beats_seen;
    check_output("t6_busy_pre", 64'(bus.o_busy), 64'd0);
    pulse_flush();
    check_output("t6_done_c1", 64'(bus.o_flush_done), 64'd0);
    cycles(1);
    check_output("t6_done_c2", 64'(bus.o_flush_done), 64'd1);
    check_output("t6_ready_c2", 64'(bus.o_ready), 64'd0);
    cycles(1);
    check_output("t6_done_c3", 64'(bus.o_flush_done), 64'd0);
    check_output("t6_ready_c3", 64'(bus.o_ready), 64'd1);
    check_output("t6_level", 64'(bus.o_level), 64'd0);
    cycles(20);
    check_output("t6_no_beats", 64'(beats_seen - b0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
